// File: rtl/nonrestoring_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : nonrestoring_div_seq
//  Description : Multicycle unsigned non-restoring divider. A single shared
//                add/subtract row produces one quotient bit per cycle over N
//                cycles. One correction cycle then fixes up the remainder.
//                Operands and results use valid/ready handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module nonrestoring_div_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         busy
);

    // Iteration counter width; N >= 2 keeps this at least one bit
    localparam int c_CW = $clog2(N);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(N - 1);

    // Controller state encoding
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ITER = 2'd1;
    localparam logic [1:0] c_CORR = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic            w_accept;

    // Datapath registers
    logic [N-1:0]    r_m;          // latched divisor
    logic [N-1:0]    r_q;          // dividend shifting out, quotient shifting in
    logic [N:0]      r_a;          // signed partial remainder, bit N is the sign
    logic [c_CW-1:0] r_cnt;

    // Result registers
    logic [N-1:0]    r_quotient;
    logic [N-1:0]    r_remainder;
    logic            r_dbz;

    // Shared add/subtract row
    logic [N:0]      w_m_ext;
    logic [N:0]      w_shift;
    logic [N:0]      w_a_next;
    logic [N:0]      w_a_corr;

    assign w_m_ext  = {1'b0, r_m};
    assign w_shift  = {r_a[N-1:0], r_q[N-1]};

    // A non-negative partial remainder subtracts the divisor, negative adds it back
    assign w_a_next = r_a[N] ? (w_shift + w_m_ext) : (w_shift - w_m_ext);

    // Final fix-up: a negative remainder is brought back into [0, M)
    assign w_a_corr = r_a[N] ? (r_a + w_m_ext) : r_a;

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

    // Controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Controller next-state and handshake outputs
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            c_IDLE: begin
                // Held low while reset is asserted, high once released
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    w_accept = 1'b1;
                    w_next   = (divisor == '0) ? c_DONE : c_ITER;
                end
            end
            c_ITER: begin
                busy = 1'b1;
                if (r_cnt == c_LAST) begin
                    w_next = c_CORR;
                end
            end
            c_CORR: begin
                busy   = 1'b1;
                w_next = c_DONE;
            end
            c_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = c_IDLE;
                end
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
    end

    // Operand latch, iteration steps and correction step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m   <= '0;
            r_q   <= '0;
            r_a   <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_m   <= divisor;
                        r_q   <= dividend;
                        r_a   <= '0;
                        r_cnt <= '0;
                    end
                end
                c_ITER: begin
                    r_a   <= w_a_next;
                    r_q   <= {r_q[N-2:0], ~w_a_next[N]};
                    r_cnt <= r_cnt + c_CW'(1);
                end
                c_CORR: begin
                    r_a <= w_a_corr;
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: loaded only by the correction step or a zero divisor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            if (w_accept && (divisor == '0)) begin
                r_quotient  <= '1;
                r_remainder <= dividend;
                r_dbz       <= 1'b1;
            end else if (r_state == c_CORR) begin
                r_quotient  <= r_q;
                r_remainder <= w_a_corr[N-1:0];
                r_dbz       <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nonrestoring_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nonrestoring_div_seq
//  Description : Directed self-checking bench for nonrestoring_div_seq with
//                an 8-bit instance and an exhaustively exercised 4-bit one.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nonrestoring_div_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 8-bit instance
    logic       in_valid, in_ready, out_valid, out_ready, dbz, busy;
    logic [7:0] dividend, divisor, quotient, remainder;

    // 4-bit instance
    logic       in_valid4, in_ready4, out_valid4, out_ready4, dbz4, busy4;
    logic [3:0] dividend4, divisor4, quotient4, remainder4;

    int n_checks = 0;
    int n_fails  = 0;

    nonrestoring_div_seq #(.N(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(dbz),
        .busy       (busy)
    );

    nonrestoring_div_seq #(.N(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid4),
        .in_ready   (in_ready4),
        .dividend   (dividend4),
        .divisor    (divisor4),
        .out_valid  (out_valid4),
        .out_ready  (out_ready4),
        .quotient   (quotient4),
        .remainder  (remainder4),
        .div_by_zero(dbz4),
        .busy       (busy4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one operand pair at a falling edge; lat counts rising edges after
    // the accepting edge until out_valid is seen.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                        input int elat, input bit consume, input string tag);
        int lat;
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(elat));
        chk({tag, " quotient"}, 32'(quotient), 32'(eq));
        chk({tag, " remainder"}, 32'(remainder), 32'(er));
        chk({tag, " dbz"}, 32'(dbz), 32'(edbz));
        if (consume) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk({tag, " out_valid after consume"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        int  lat;
        bit  seen;
        logic [3:0] eq4, er4;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        dividend   = '0;
        divisor    = '0;
        in_valid4  = 1'b0;
        out_ready4 = 1'b0;
        dividend4  = '0;
        divisor4   = '0;

        // Reset state
        #12;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset quotient", 32'(quotient), 32'd0);
        chk("reset remainder", 32'(remainder), 32'd0);
        chk("reset dbz", 32'(dbz), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", 32'(in_ready), 32'd1);

        // Directed divisions (N=8)
        run8(8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 9, 1'b1, "100/7");
        run8(8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 9, 1'b1, "255/1");
        run8(8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 9, 1'b1, "5/9");
        run8(8'd200, 8'd200, 8'd1,   8'd0,  1'b0, 9, 1'b1, "200/200");
        run8(8'd0,   8'd13,  8'd0,   8'd0,  1'b0, 9, 1'b1, "0/13");
        // Zero divisor goes straight to DONE on the accepting edge
        run8(8'd37,  8'd0,   8'hFF,  8'd37, 1'b1, 0, 1'b1, "37/0");

        // Backpressure: result held for 5 cycles with out_ready low
        run8(8'd123, 8'd10, 8'd12, 8'd3, 1'b0, 9, 1'b0, "bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp out_valid held", 32'(out_valid), 32'd1);
            chk("bp in_ready low", 32'(in_ready), 32'd0);
            chk("bp quotient held", 32'(quotient), 32'd12);
            chk("bp remainder held", 32'(remainder), 32'd3);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp in_ready after consume", 32'(in_ready), 32'd1);
        chk("bp out_valid after consume", 32'(out_valid), 32'd0);
        chk("bp quotient kept", 32'(quotient), 32'd12);

        // New operands pulsed during ITER are ignored
        in_valid = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ign busy", 32'(busy), 32'd1);
        in_valid = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd3;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 3;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("ign latency", 32'(lat), 32'd9);
        chk("ign quotient", 32'(quotient), 32'd14);
        chk("ign remainder", 32'(remainder), 32'd2);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("ign no second result", 32'(seen), 32'd0);

        // Reset in ITER at cnt=3 aborts the division
        in_valid = 1'b1;
        dividend = 8'd77;
        divisor  = 8'd3;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort quotient", 32'(quotient), 32'd0);
        chk("abort remainder", 32'(remainder), 32'd0);
        chk("abort dbz", 32'(dbz), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort no result", 32'(seen), 32'd0);
        run8(8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 9, 1'b1, "50/5");

        // N=4 exhaustive with random result stalls
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                in_valid4 = 1'b1;
                dividend4 = 4'(a);
                divisor4  = 4'(b);
                @(negedge clk);
                in_valid4 = 1'b0;
                lat = 0;
                while (!out_valid4 && lat < 20) begin
                    @(negedge clk);
                    lat++;
                end
                if (!out_valid4) chk("n4 timeout", 32'(out_valid4), 32'd1);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                eq4 = (b == 0) ? 4'hF : 4'(a / b);
                er4 = (b == 0) ? 4'(a) : 4'(a % b);
                chk($sformatf("n4 %0d/%0d quotient", a, b), 32'(quotient4), 32'(eq4));
                chk($sformatf("n4 %0d/%0d remainder", a, b), 32'(remainder4), 32'(er4));
                chk($sformatf("n4 %0d/%0d dbz", a, b), 32'(dbz4), 32'(b == 0));
                out_ready4 = 1'b1;
                @(negedge clk);
                out_ready4 = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
